// File: rtl/dfi_init_seq_pkg.sv
// Shared types and default parameter values for the DFI init handshake sequencer.
package dfi_init_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILTER    = 3'd1,
        ST_HANDSHAKE = 3'd2,
        ST_DONE      = 3'd3,
        ST_ERROR     = 3'd4
    } dfi_init_seq_state_e;

    localparam int DefStartFilter   = 4;
    localparam int DefTimeoutCycles = 65536;
    localparam int DefCntW          = 8;

endpackage

// File: rtl/dfi_init_seq_timer.sv
// Handshake supervision counter: clears while clr_i, counts while en_i, flags the last allowed cycle.
module dfi_init_seq_timer #(
    parameter int TimeoutCycles = 65536
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int TW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == TW'(TimeoutCycles - 1));

endmodule

// File: rtl/dfi_init_seq.sv
// DFI init start/complete sequencer between the controller and dfi_gpio firmware CSRs.
// Optional handshake timeout enabled by defining DFI_INIT_SEQ_TIMEOUT_EN.
module dfi_init_seq
    import dfi_init_seq_pkg::*;
#(
    parameter int StartFilter   = DefStartFilter,
    parameter int TimeoutCycles = DefTimeoutCycles,
    parameter int CntW          = DefCntW
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            dfi_init_start_i,
    output logic            dfi_init_complete_o,
    output logic            gpio_init_start_o,
    input  logic            gpio_init_done_i,
    output logic            timeout_o,
    output logic [CntW-1:0] init_count_o
);

    localparam int FW = $clog2(StartFilter + 1);

    dfi_init_seq_state_e state_q, state_d;
    logic [FW-1:0]   filt_q, filt_d;
    logic            complete_q, complete_d;
    logic            gpio_start_q, gpio_start_d;
    logic [CntW-1:0] count_q, count_d;
    logic            done_q;
    logic            done_edge;
    logic            enter_hs;
    logic            expired;

`ifdef DFI_INIT_SEQ_TIMEOUT_EN
    logic timeout_q, timeout_d;

    dfi_init_seq_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (state_q != ST_HANDSHAKE),
        .en_i     (state_q == ST_HANDSHAKE),
        .expired_o(expired)
    );

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TimeoutCycles > 1);
    assign expired            = 1'b0;
    assign timeout_o          = 1'b0;
`endif

    // Only a rising level counts, so a done left high from the previous handshake is ignored.
    assign done_edge = gpio_init_done_i & ~done_q;

    always_comb begin
        state_d      = state_q;
        filt_d       = filt_q;
        complete_d   = complete_q;
        gpio_start_d = gpio_start_q;
        count_d      = count_q;
        enter_hs     = 1'b0;
`ifdef DFI_INIT_SEQ_TIMEOUT_EN
        timeout_d    = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (dfi_init_start_i) begin
                    if (StartFilter == 1) begin
                        enter_hs = 1'b1;
                    end else begin
                        state_d = ST_FILTER;
                        filt_d  = FW'(1);
                    end
                end
            end
            ST_FILTER: begin
                if (!dfi_init_start_i) begin
                    state_d = ST_IDLE;
                end else begin
                    filt_d = filt_q + 1'b1;
                    if (filt_q == FW'(StartFilter - 1)) begin
                        enter_hs = 1'b1;
                    end
                end
            end
            ST_HANDSHAKE: begin
                if (done_edge) begin
                    state_d      = ST_DONE;
                    complete_d   = 1'b1;
                    gpio_start_d = 1'b0;
                    count_d      = count_q + 1'b1;
                end else if (!dfi_init_start_i) begin
                    state_d      = ST_IDLE;
                    gpio_start_d = 1'b0;
                end else if (expired) begin
                    gpio_start_d = 1'b0;
`ifdef DFI_INIT_SEQ_TIMEOUT_EN
                    state_d      = ST_ERROR;
                    timeout_d    = 1'b1;
`endif
                end
            end
            ST_DONE: begin
                if (!dfi_init_start_i) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef DFI_INIT_SEQ_TIMEOUT_EN
            ST_ERROR: begin
                if (!dfi_init_start_i) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d      = ST_IDLE;
                gpio_start_d = 1'b0;
            end
        endcase

        if (enter_hs) begin
            state_d      = ST_HANDSHAKE;
            gpio_start_d = 1'b1;
            complete_d   = 1'b0;
`ifdef DFI_INIT_SEQ_TIMEOUT_EN
            timeout_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            filt_q       <= '0;
            complete_q   <= 1'b0;
            gpio_start_q <= 1'b0;
            count_q      <= '0;
            done_q       <= 1'b1;
`ifdef DFI_INIT_SEQ_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            filt_q       <= filt_d;
            complete_q   <= complete_d;
            gpio_start_q <= gpio_start_d;
            count_q      <= count_d;
            done_q       <= gpio_init_done_i;
`ifdef DFI_INIT_SEQ_TIMEOUT_EN
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign dfi_init_complete_o = complete_q;
    assign gpio_init_start_o   = gpio_start_q;
    assign init_count_o        = count_q;

endmodule

// File: doc/dfi_init_seq.md
# dfi_init_seq

DFI initialization handshake sequencer between the DDR controller's DFI init signals and the `dfi_gpio` CSR block. It filters the controller's `dfi_init_start` and forwards it to `dfi_gpio`, where firmware sees it. It waits for firmware to raise `init_done`, then returns `dfi_init_complete` to the controller. It also supervises the handshake with a timeout and counts completed handshakes.

## Interface
- `StartFilter`, default 4: consecutive high samples of `dfi_init_start_i` required to accept a start; legal range ≥1.
- `TimeoutCycles`, default 65536: maximum cycles spent in HANDSHAKE; legal range ≥2.
- `CntW`, default 8: width of `init_count_o`.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `dfi_init_start_i`, in, 1: init/frequency-change request from the controller.
- `dfi_init_complete_o`, out, 1: init complete, to the controller.
- `gpio_init_start_o`, out, 1: to the `dfi_gpio` `dfi_init_start_i` input.
- `gpio_init_done_i`, in, 1: from the `dfi_gpio` `dfi_init_done_o` output (firmware-written level).
- `timeout_o`, out, 1: handshake timed out; sticky.
- `init_count_o`, out, CntW: number of completed handshakes; wraps.

## Operation
- States: IDLE, FILTER, HANDSHAKE, DONE, ERROR. Encoding lives in the package.
- IDLE:
  - `start_i`=1 with StartFilter=1 → HANDSHAKE.
  - `start_i`=1 with StartFilter>1 → FILTER, with `filt_cnt`=1.
- FILTER:
  - `start_i`=0 → IDLE; outputs unchanged.
  - Otherwise `filt_cnt`++; when `filt_cnt`==StartFilter-1 at the sampling edge → HANDSHAKE.
- Entering HANDSHAKE:
  - `dfi_init_complete_o`←0, `timeout_o`←0, timer←0.
  - `gpio_init_start_o`=1 for as long as the state is HANDSHAKE.
- HANDSHAKE:
  - Done edge = `gpio_init_done_i`=1 AND `done_q`=0. `done_q` is a register tracking `gpio_init_done_i` every cycle, with reset value 1.
  - A `done_i` held high from a previous handshake is never accepted; firmware must write 0 and then 1.
  - Done edge → DONE, `dfi_init_complete_o`←1, `init_count_o`++ (wraps from 2^CntW-1 to 0).
  - `start_i`=0 (abort) → IDLE; complete stays 0; count unchanged.
  - Timer reaches TimeoutCycles-1 with no done edge → ERROR, `timeout_o`←1.
  - Priority: done edge > abort > timeout.
- DONE: complete held at 1; `start_i`=0 → IDLE. Complete stays 1 in IDLE until the next accepted start.
- ERROR: `gpio_init_start_o`=0, complete=0; `start_i`=0 → IDLE. `timeout_o` stays 1 until the next HANDSHAKE entry.
- Reset mid-operation: all state returns to reset values at the next edge. `gpio_init_start_o` drops without waiting for firmware.

## Timing
- Reset values:
  - state IDLE.
  - `dfi_init_complete_o`=0, `gpio_init_start_o`=0, `timeout_o`=0, `init_count_o`=0.
  - `filt_cnt`=0, timer=0, `done_q`=1.
- All outputs are registered; there are no combinational input-to-output paths.
- Start acceptance: `start_i` first sampled high at edge k → `gpio_init_start_o` and complete=0 from edge k+StartFilter-1.
  - Example, StartFilter=1: outputs change at edge k.
- Done latency: done edge sampled at edge j → complete=1, `gpio_init_start_o`=0 and count updated, all from edge j.
- Timeout: ERROR entered exactly TimeoutCycles edges after HANDSHAKE entry.
- A new start may be accepted the edge after returning to IDLE.

## Configuration
- `DFI_INIT_SEQ_TIMEOUT_EN` defined: timer, ERROR state and the `timeout_o` behaviour are as described above.
- `DFI_INIT_SEQ_TIMEOUT_EN` undefined:
  - No timer and no ERROR state are synthesized.
  - `timeout_o` is tied to 0 and `TimeoutCycles` is ignored.
  - HANDSHAKE waits indefinitely for a done edge or an abort.

## Structure
- `dfi_init_seq_pkg`: state enum `dfi_init_seq_state_e`, default constants for `StartFilter`, `TimeoutCycles` and `CntW`.
- Sub-module `dfi_init_seq_timer`: clear/enable counter with an `expired` flag, instantiated only under the macro.
- The FSM, filter, done edge detect and counter stay in the top module.

## Test plan
- Reset → all outputs 0.
- Start pulse shorter than the filter: StartFilter=4, `start_i` high for 3 cycles → `gpio_init_start_o` never rises; state returns to IDLE.
- Normal handshake:
  - `start_i` high from edge 10 → `gpio_init_start_o`=1 at edge 13.
  - `done_i` 0→1 at edge 20 → complete=1, `gpio_init_start_o`=0 and count=1 at edge 20.
  - `start_i` low → complete remains 1.
- Stale done: `done_i` held 1 across a new start → no completion until `done_i` goes 0 then 1; count then increments by 1.
- Timeout: TimeoutCycles=16, no done → `timeout_o`=1 at HANDSHAKE entry + 16, complete=0. Next accepted start clears `timeout_o`. Without the macro, no timeout occurs after 1000 cycles.
- Abort and wrap:
  - `start_i` low mid-HANDSHAKE → IDLE, count unchanged.
  - CntW=2 with 5 completions → `init_count_o`=1.
  - Reset asserted in HANDSHAKE → `gpio_init_start_o`=0 the next edge.
